// File: rtl/mem_port_arb_if.sv
// Signal bundle between the two requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_port_arb_if #(
    parameter int WIDTH = 128,
    parameter int AW    = 6
);
    logic             req0;
    logic             req1;
    logic             lock0;
    logic             lock1;
    logic             we0;
    logic             we1;
    logic [AW-1:0]    addr0;
    logic [AW-1:0]    addr1;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic             gnt0;
    logic             gnt1;
    logic             rvalid0;
    logic             rvalid1;
    logic [WIDTH-1:0] rdata;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_di;
    logic [WIDTH-1:0] mem_do;

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, din0, din1, mem_do,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_we, mem_addr, mem_di
    );

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, din0, din1, mem_do,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_we, mem_addr, mem_di
    );
endinterface

// File: rtl/mem_port_arb.sv
// Two-requester arbiter for a single-port synchronous-read memory: round-robin on ties,
// zero-gap handover, hold-time preemption unless the owner locks, one-cycle read valid.
module mem_port_arb #(
    parameter int WIDTH   = 128,
    parameter int AW      = 6,
    parameter int MAXHOLD = 64
) (
    input  logic           clk,
    input  logic           rst_b,
    mem_port_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAXHOLD - 1);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;
    logic       issue0, issue1;
    logic       hold_expired;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= 8'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        hold_d       = hold_q;
        issue0       = (state_q == OWN0) && bus.req0;
        issue1       = (state_q == OWN1) && bus.req1;
        hold_expired = (hold_q >= HOLD_LIM);

        case (state_q)
            IDLE: begin
                // last names the most recent owner, so a tie goes to the other one
                if (bus.req0 && bus.req1) state_d = last_q ? OWN0 : OWN1;
                else if (bus.req0)        state_d = OWN0;
                else if (bus.req1)        state_d = OWN1;
            end
            OWN0: begin
                if (!bus.req0)
                    state_d = bus.req1 ? OWN1 : IDLE;
                else if (hold_expired && !bus.lock0 && bus.req1)
                    state_d = OWN1;
                if (state_d != OWN0) last_d = 1'b0;
            end
            OWN1: begin
                if (!bus.req1)
                    state_d = bus.req0 ? OWN0 : IDLE;
                else if (hold_expired && !bus.lock1 && bus.req0)
                    state_d = OWN0;
                if (state_d != OWN1) last_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            hold_d = 8'd0;
        else if (state_q != IDLE && hold_q != 8'd255)
            hold_d = hold_q + 8'd1;

        rvalid0_d = issue0 && !bus.we0;
        rvalid1_d = issue1 && !bus.we1;
    end

    // Memory drive is combinational from the owner so the access lands in the grant cycle.
    always_comb begin
        bus.mem_we   = 1'b0;
        bus.mem_addr = {AW{1'b0}};
        bus.mem_di   = {WIDTH{1'b0}};
        if (issue0) begin
            bus.mem_we   = bus.we0;
            bus.mem_addr = bus.addr0;
            bus.mem_di   = bus.din0;
        end else if (issue1) begin
            bus.mem_we   = bus.we1;
            bus.mem_addr = bus.addr1;
            bus.mem_di   = bus.din1;
        end
    end

    assign bus.gnt0    = (state_q == OWN0);
    assign bus.gnt1    = (state_q == OWN1);
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata   = bus.mem_do;
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a small synchronous-read memory model on the
// memory port; every expectation below is hand-derived from the arbitration rules.
module tb_mem_port_arb;
    localparam int WIDTH   = 16;
    localparam int AW      = 6;
    localparam int MAXHOLD = 4;

    logic clk;
    logic rst_b;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_arb_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    mem_port_arb #(.WIDTH(WIDTH), .AW(AW), .MAXHOLD(MAXHOLD)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    logic [WIDTH-1:0] mem [64];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_di;
        bus.mem_do <= mem[bus.mem_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
        bus.we0  = 0; bus.we1  = 0;
    endtask

    task automatic test_reset();
        rst_b = 1'b1;
        drop_all();
        bus.addr0 = 0; bus.addr1 = 0; bus.din0 = 0; bus.din1 = 0;
        #1;
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 6'd9; bus.din0 = 16'h1234;
        tick();
        n_cmp++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b%b want 00", bus.gnt0, bus.gnt1); end
        n_cmp++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b%b want 00", bus.rvalid0, bus.rvalid1); end
        n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 6'd0) begin n_err++; $display("FAIL reset_mem: we=%b addr=%0d want 0/0", bus.mem_we, bus.mem_addr); end
        drop_all();
        tick();
        rst_b = 1'b0;
        $display("reset: gnt=%b%b mem_we=%b", bus.gnt0, bus.gnt1, bus.mem_we);
    endtask

    task automatic test_first_tie();
        bus.req0 = 1; bus.req1 = 1;
        tick();
        n_cmp++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_err++; $display("FAIL first_tie: got %b%b want 10", bus.gnt0, bus.gnt1); end
        bus.req0 = 0;
        tick();
        n_cmp++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b1) begin n_err++; $display("FAIL handover_no_gap: got %b%b want 01", bus.gnt0, bus.gnt1); end
        bus.req1 = 0;
        tick();
        n_cmp++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin n_err++; $display("FAIL release_idle: got %b%b want 00", bus.gnt0, bus.gnt1); end
        $display("first_tie: done");
    endtask

    task automatic test_round_robin();
        bus.req0 = 1; tick(); bus.req0 = 0; tick();
        bus.req0 = 1; bus.req1 = 1;
        tick();
        n_cmp++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin n_err++; $display("FAIL rr_tie_to_1: got %b%b want 01", bus.gnt0, bus.gnt1); end
        drop_all(); tick();
        bus.req0 = 1; bus.req1 = 1;
        tick();
        n_cmp++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_err++; $display("FAIL rr_tie_to_0: got %b%b want 10", bus.gnt0, bus.gnt1); end
        drop_all(); tick();
        $display("round_robin: done");
    endtask

    task automatic test_read();
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 6'd5; bus.din0 = 16'h00A5;
        tick();
        n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd5 || bus.mem_di !== 16'h00A5) begin n_err++; $display("FAIL write_drive: we=%b addr=%0d di=%h want 1/5/00a5", bus.mem_we, bus.mem_addr, bus.mem_di); end
        tick();
        bus.we0 = 0;
        #1;
        n_cmp++; if (bus.rvalid0 !== 1'b0) begin n_err++; $display("FAIL write_no_rvalid: got %b want 0", bus.rvalid0); end
        tick();
        n_cmp++; if (bus.rvalid0 !== 1'b1 || bus.rdata !== 16'h00A5) begin n_err++; $display("FAIL read_latency: rvalid0=%b rdata=%h want 1/00a5", bus.rvalid0, bus.rdata); end
        n_cmp++; if (bus.rvalid1 !== 1'b0) begin n_err++; $display("FAIL read_rvalid1: got %b want 0", bus.rvalid1); end
        bus.req0 = 0;
        #1;
        n_cmp++; if (bus.rvalid0 !== 1'b1) begin n_err++; $display("FAIL rvalid_after_drop: got %b want 1", bus.rvalid0); end
        tick();
        n_cmp++; if (bus.rvalid0 !== 1'b0 || bus.gnt0 !== 1'b0) begin n_err++; $display("FAIL read_done: rvalid0=%b gnt0=%b want 0/0", bus.rvalid0, bus.gnt0); end
        $display("read: rdata path checked at addr 5");
    endtask

    task automatic test_isolation();
        bus.req0 = 1; bus.lock0 = 1; bus.we0 = 0; bus.addr0 = 6'd7; bus.din0 = 16'h0707;
        tick();
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 6'd3; bus.din1 = 16'hBEEF;
        #1;
        n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 6'd7 || bus.mem_di !== 16'h0707) begin n_err++; $display("FAIL isolation: we=%b addr=%0d di=%h want 0/7/0707", bus.mem_we, bus.mem_addr, bus.mem_di); end
        repeat (5) tick();
        n_cmp++; if (bus.gnt0 !== 1'b1 || bus.mem_addr !== 6'd7) begin n_err++; $display("FAIL isolation_hold: gnt0=%b addr=%0d want 1/7", bus.gnt0, bus.mem_addr); end
        drop_all(); tick();
        $display("isolation: done");
    endtask

    task automatic test_preempt();
        int  n_gnt1;
        bit  seen1;
        bus.req0 = 1;
        tick();
        bus.req1 = 1;
        n_gnt1 = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.gnt1 === 1'b1 && n_gnt1 == 0) n_gnt1 = i;
        end
        n_cmp++; if (n_gnt1 != 4) begin n_err++; $display("FAIL preempt_cycles: got %0d want 4", n_gnt1); end
        drop_all(); tick();
        bus.req0 = 1; bus.lock0 = 1;
        tick();
        bus.req1 = 1;
        seen1 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.gnt1 !== 1'b0 || bus.gnt0 !== 1'b1) seen1 = 1;
        end
        n_cmp++; if (seen1) begin n_err++; $display("FAIL lock_hold: grant left owner 0 while locked"); end
        bus.lock0 = 0;
        tick();
        n_cmp++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin n_err++; $display("FAIL unlock_preempt: got %b%b want 01", bus.gnt0, bus.gnt1); end
        drop_all(); tick();
        $display("preempt: first gnt1 after %0d cycles", n_gnt1);
    endtask

    task automatic test_mid_reset();
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 6'd5; bus.din0 = 16'h00A5;
        tick();
        bus.we0 = 0;
        #1;
        rst_b = 1'b1;
        #1;
        n_cmp++; if (bus.rvalid0 !== 1'b0 || bus.gnt0 !== 1'b0 || bus.mem_we !== 1'b0) begin n_err++; $display("FAIL midreset_async: rvalid0=%b gnt0=%b mem_we=%b want 000", bus.rvalid0, bus.gnt0, bus.mem_we); end
        tick();
        n_cmp++; if (bus.rvalid0 !== 1'b0) begin n_err++; $display("FAIL midreset_rvalid: got %b want 0", bus.rvalid0); end
        drop_all();
        rst_b = 1'b0;
        tick();
        n_cmp++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.rvalid0 !== 1'b0) begin n_err++; $display("FAIL midreset_idle: gnt=%b%b rvalid0=%b want 000", bus.gnt0, bus.gnt1, bus.rvalid0); end
        bus.req0 = 1; bus.req1 = 1;
        tick();
        n_cmp++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_err++; $display("FAIL midreset_tie: got %b%b want 10", bus.gnt0, bus.gnt1); end
        drop_all(); tick();
        $display("mid_reset: done");
    endtask

    initial begin
        test_reset();
        test_first_tie();
        test_round_robin();
        test_read();
        test_isolation();
        test_preempt();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
